// File: rtl/prog_mem_loader.sv
// Program-image loader: takes a length/payload/checksum frame from a host word stream,
// writes the payload into program memory and holds the core until the image is verified.
//
// state | meaning
// IDLE  | out of reset, waiting for start
// LEN   | waiting for the length word L (payload is L+1 words)
// LOAD  | writing payload words to consecutive addresses from 0
// CSUM  | waiting for the XOR checksum word
// DONE  | last load verified, core released
// ERR   | last load failed (length overflow, bad checksum or abort)
module prog_mem_loader #(
  parameter int DATA_SIZE = 6,
  parameter int ADDR_SIZE = 5
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 start,
  input  logic                 abort,
  input  logic [DATA_SIZE-1:0] in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic                 mem_we,
  output logic [ADDR_SIZE-1:0] mem_addr,
  output logic [DATA_SIZE-1:0] mem_wdata,
  output logic                 cpu_hold,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_LOAD,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_t;

  state_t                 state_q, state_d;
  logic [ADDR_SIZE-1:0]   cnt_q, cnt_d;
  logic [ADDR_SIZE-1:0]   addr_q, addr_d;
  logic [DATA_SIZE-1:0]   csum_q, csum_d;
  logic                   we_q, we_d;
  logic [ADDR_SIZE-1:0]   waddr_q, waddr_d;
  logic [DATA_SIZE-1:0]   wdata_q, wdata_d;
  logic                   loading;
  logic                   accept;
  logic                   len_ovf;

  assign loading  = (state_q == S_LEN) || (state_q == S_LOAD) || (state_q == S_CSUM);
  assign in_ready = loading;
  // abort wins over a word presented in the same cycle
  assign accept   = in_valid && loading && !abort;
  assign len_ovf  = (in_data >> ADDR_SIZE) != '0;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    csum_d  = csum_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d = S_LEN;
          csum_d  = '0;
        end
      end
      S_LEN: begin
        if (abort) begin
          state_d = S_ERR;
        end else if (accept) begin
          if (len_ovf) begin
            state_d = S_ERR;
          end else begin
            cnt_d   = ADDR_SIZE'(in_data);
            addr_d  = '0;
            state_d = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        if (abort) begin
          state_d = S_ERR;
        end else if (accept) begin
          we_d    = 1'b1;
          waddr_d = addr_q;
          wdata_d = in_data;
          csum_d  = csum_q ^ in_data;
          // compare against N-1 so a full-depth image never wraps the address
          if (addr_q == cnt_q) state_d = S_CSUM;
          else                 addr_d  = addr_q + ADDR_SIZE'(1);
        end
      end
      S_CSUM: begin
        if (abort)       state_d = S_ERR;
        else if (accept) state_d = (in_data == csum_q) ? S_DONE : S_ERR;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      csum_q  <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      csum_q  <= csum_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

  assign mem_we    = we_q;
  assign mem_addr  = waddr_q;
  assign mem_wdata = wdata_q;
  assign busy      = loading;
  assign cpu_hold  = loading;
  assign done      = (state_q == S_DONE);
  assign err       = (state_q == S_ERR);

endmodule

// File: tb/tb_prog_mem_loader.sv
// Directed bench for prog_mem_loader: frames are streamed in and every memory write is logged
// with the cycle it appeared, so write order, addresses, data and latency can be checked.
module tb_prog_mem_loader;
  localparam int DW = 6;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rstn, start, abort, in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready, mem_we, cpu_hold, busy, done, err;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;

  int passed = 0;
  int total  = 0;
  int cyc    = 0;
  int wr_addr[$];
  int wr_data[$];
  int wr_cyc[$];

  prog_mem_loader #(.DATA_SIZE(DW), .ADDR_SIZE(AW)) dut (
    .clk(clk), .rstn(rstn), .start(start), .abort(abort),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_hold(cpu_hold), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // write log; a word accepted in the half-cycle stamped c must show up here as c
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      wr_addr.push_back(int'(mem_addr));
      wr_data.push_back(int'(mem_wdata));
      wr_cyc.push_back(cyc);
    end
    cyc++;
  end

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
    wr_cyc.delete();
  endtask

  task automatic idle();
    @(negedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk); #1;
    in_valid = 1'b0;
    start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_word(input logic [DW-1:0] d, input int gap, output int stamp);
    bit ok;
    ok = 0;
    stamp = -1;
    repeat (gap) begin
      @(negedge clk); #1;
      in_valid = 1'b0;
    end
    @(negedge clk); #1;
    in_data  = d;
    in_valid = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin
      if (in_ready === 1'b1) begin
        stamp = cyc;
        ok = 1;
        @(posedge clk);
      end else begin
        @(negedge clk); #1;
      end
    end
    if (!ok) begin
      total++;
      $display("FAIL send_timeout: word %h not accepted within 50 cycles", d);
    end
  endtask

  task automatic test_reset();
    #2;
    total++;
    if ({in_ready, mem_we, busy, done, err, cpu_hold} !== 6'b0)
      $display("FAIL reset_flags: got %b want 000000", {in_ready, mem_we, busy, done, err, cpu_hold});
    else passed++;
    total++;
    if ({mem_addr, mem_wdata} !== '0)
      $display("FAIL reset_bus: got addr %h data %h want 0 0", mem_addr, mem_wdata);
    else passed++;
    repeat (2) @(negedge clk);
    #1 rstn = 1'b1;
  endtask

  task automatic run_small_frame(input logic [DW-1:0] csum, output int st0, output int st1, output int st2);
    int s;
    clear_log();
    pulse_start();
    total++;
    if ({busy, cpu_hold, done, err} !== 4'b1100)
      $display("FAIL start_flags: got busy,hold,done,err=%b want 1100", {busy, cpu_hold, done, err});
    else passed++;
    send_word(6'd2, 0, s);
    send_word(6'h05, 0, st0);
    send_word(6'h11, 0, st1);
    send_word(6'h3F, 0, st2);
    send_word(csum, 0, s);
    idle();
  endtask

  task automatic test_good_frame();
    int st0, st1, st2;
    int exp_addr[3] = '{0, 1, 2};
    int exp_data[3] = '{'h05, 'h11, 'h3F};
    int exp_cyc[3];
    run_small_frame(6'h2B, st0, st1, st2);
    exp_cyc = '{st0, st1, st2};
    total++;
    if (wr_addr.size() !== 3) $display("FAIL good_wr_count: got %0d want 3", wr_addr.size());
    else passed++;
    for (int i = 0; i < 3 && i < wr_addr.size(); i++) begin
      total++;
      if (wr_addr[i] !== exp_addr[i] || wr_data[i] !== exp_data[i] || wr_cyc[i] !== exp_cyc[i])
        $display("FAIL good_write%0d: got addr %0d data %h cyc %0d want addr %0d data %h cyc %0d",
                 i, wr_addr[i], wr_data[i], wr_cyc[i], exp_addr[i], exp_data[i], exp_cyc[i]);
      else passed++;
    end
    total++;
    if ({done, err, busy, cpu_hold, mem_we} !== 5'b10000)
      $display("FAIL good_status: got done,err,busy,hold,we=%b want 10000", {done, err, busy, cpu_hold, mem_we});
    else passed++;
  endtask

  task automatic test_bad_checksum();
    int st0, st1, st2;
    run_small_frame(6'h2A, st0, st1, st2);
    total++;
    if (wr_addr.size() !== 3) $display("FAIL bad_wr_count: got %0d want 3", wr_addr.size());
    else passed++;
    total++;
    if ({done, err, busy, cpu_hold} !== 4'b0100)
      $display("FAIL bad_status: got done,err,busy,hold=%b want 0100", {done, err, busy, cpu_hold});
    else passed++;
  endtask

  task automatic test_len_overflow();
    int s;
    clear_log();
    pulse_start();
    total++;
    if ({done, err} !== 2'b00) $display("FAIL ovf_clear: got done,err=%b want 00", {done, err});
    else passed++;
    send_word(6'd40, 0, s);
    idle();
    total++;
    if ({err, in_ready, busy, cpu_hold} !== 4'b1000)
      $display("FAIL ovf_status: got err,ready,busy,hold=%b want 1000", {err, in_ready, busy, cpu_hold});
    else passed++;
    repeat (3) @(negedge clk);
    total++;
    if (wr_addr.size() !== 0) $display("FAIL ovf_writes: got %0d want 0", wr_addr.size());
    else passed++;
  endtask

  task automatic test_full_depth();
    int s;
    int bad;
    clear_log();
    pulse_start();
    send_word(6'd31, 0, s);
    for (int i = 0; i < 32; i++) send_word(DW'(i), int'($urandom_range(0, 2)), s);
    send_word(6'h00, int'($urandom_range(0, 2)), s);
    idle();
    total++;
    if (wr_addr.size() !== 32) $display("FAIL full_wr_count: got %0d want 32", wr_addr.size());
    else passed++;
    bad = 0;
    for (int i = 0; i < wr_addr.size(); i++)
      if (wr_addr[i] !== i || wr_data[i] !== i) bad++;
    total++;
    if (bad !== 0) $display("FAIL full_sequence: got %0d out-of-order writes want 0", bad);
    else passed++;
    total++;
    if ({done, err} !== 2'b10) $display("FAIL full_status: got done,err=%b want 10", {done, err});
    else passed++;
  endtask

  task automatic test_start_abort_during_load();
    int s;
    clear_log();
    pulse_start();
    send_word(6'd4, 0, s);
    send_word(6'h01, 0, s);
    pulse_start();
    total++;
    if ({busy, done, err} !== 3'b100)
      $display("FAIL start_ignored: got busy,done,err=%b want 100", {busy, done, err});
    else passed++;
    send_word(6'h02, 0, s);
    @(negedge clk); #1;
    in_data  = 6'h03;
    in_valid = 1'b1;
    abort    = 1'b1;
    @(negedge clk); #1;
    abort    = 1'b0;
    in_valid = 1'b0;
    total++;
    if ({err, done, busy, cpu_hold, in_ready} !== 5'b10000)
      $display("FAIL abort_status: got err,done,busy,hold,ready=%b want 10000", {err, done, busy, cpu_hold, in_ready});
    else passed++;
    repeat (2) @(negedge clk);
    total++;
    if (wr_addr.size() !== 2) $display("FAIL abort_wr_count: got %0d want 2", wr_addr.size());
    else passed++;
    if (wr_addr.size() == 2) begin
      total++;
      if (wr_addr[1] !== 1 || wr_data[1] !== 'h02)
        $display("FAIL abort_write1: got addr %0d data %h want addr 1 data 02", wr_addr[1], wr_data[1]);
      else passed++;
    end
  endtask

  task automatic test_reset_mid_load();
    int s;
    clear_log();
    pulse_start();
    send_word(6'd3, 0, s);
    send_word(6'h07, 0, s);
    @(negedge clk); #1;
    in_valid = 1'b0;
    rstn = 1'b0;
    #1;
    total++;
    if ({in_ready, mem_we, busy, done, err, cpu_hold, mem_addr, mem_wdata} !== '0)
      $display("FAIL midreset_outputs: got ready,we,busy,done,err,hold=%b addr %h data %h want all 0",
               {in_ready, mem_we, busy, done, err, cpu_hold}, mem_addr, mem_wdata);
    else passed++;
    @(negedge clk); #1;
    rstn = 1'b1;
    clear_log();
    pulse_start();
    send_word(6'd0, 0, s);
    send_word(6'h15, 0, s);
    send_word(6'h15, 0, s);
    idle();
    repeat (2) @(negedge clk);
    total++;
    if (wr_addr.size() !== 1) $display("FAIL reload_wr_count: got %0d want 1", wr_addr.size());
    else passed++;
    if (wr_addr.size() == 1) begin
      total++;
      if (wr_addr[0] !== 0 || wr_data[0] !== 'h15)
        $display("FAIL reload_write: got addr %0d data %h want addr 0 data 15", wr_addr[0], wr_data[0]);
      else passed++;
    end
    total++;
    if ({done, err} !== 2'b10) $display("FAIL reload_status: got done,err=%b want 10", {done, err});
    else passed++;
  endtask

  initial begin
    rstn     = 1'b0;
    start    = 1'b0;
    abort    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    test_reset();
    test_good_frame();
    test_bad_checksum();
    test_len_overflow();
    test_full_depth();
    test_start_abort_during_load();
    test_reset_mid_load();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
